// File: rtl/demux_1to2_32bit_reg.sv
`default_nettype none
// ============================================================================
// Module   : demux_1to2_32bit_reg
// Purpose  : Registered 1-to-2 demultiplexer with valid/ready handshakes.
//            One input word is steered to port A (in_sel=0) or port B
//            (in_sel=1). Each port has a one-entry holding register that
//            keeps its word until the consumer accepts it, so the two sinks
//            can stall independently without blocking each other.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   WIDTH        data width of the input and both outputs (default 32)
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   in_data      word to route
//   in_sel       destination: 0 = port A, 1 = port B
//   in_valid     in_data/in_sel valid
//   in_ready     demux accepts the input this cycle
//   out_a_data   port A held word
//   out_a_valid  port A register full
//   out_a_ready  port A consumer accepts
//   out_b_data   port B held word
//   out_b_valid  port B register full
//   out_b_ready  port B consumer accepts
//   cnt_a/cnt_b  (DEMUX_COUNT_EN only) 16-bit wrapping counts of completed
//                output transfers on each port
// Build option:
//   DEMUX_COUNT_EN  define to add the cnt_a/cnt_b transfer counters
// ============================================================================
module demux_1to2_32bit_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_a_data,
  output logic             out_a_valid,
  input  logic             out_a_ready,
  output logic [WIDTH-1:0] out_b_data,
  output logic             out_b_valid,
  input  logic             out_b_ready
`ifdef DEMUX_COUNT_EN
  ,
  output logic [15:0]      cnt_a,
  output logic [15:0]      cnt_b
`endif
);

  logic [WIDTH-1:0] r_a_data;
  logic             r_a_valid;
  logic [WIDTH-1:0] r_b_data;
  logic             r_b_valid;

  logic w_a_take;
  logic w_b_take;
  logic w_load_a;
  logic w_load_b;
  logic w_drain_a;
  logic w_drain_b;

  // A port can take a word when empty, or when full and being drained in
  // this same cycle (drain-and-refill keeps one word per cycle, no bubble).
  assign w_a_take = ~r_a_valid | out_a_ready;
  assign w_b_take = ~r_b_valid | out_b_ready;

  // Only the selected port's state matters; in_valid is deliberately not
  // part of in_ready so the handshake has no valid->ready loop.
  assign in_ready = in_sel ? w_b_take : w_a_take;

  assign w_load_a  = in_valid & in_ready & ~in_sel;
  assign w_load_b  = in_valid & in_ready &  in_sel;
  assign w_drain_a = r_a_valid & out_a_ready;
  assign w_drain_b = r_b_valid & out_b_ready;

  // Port A holding register. Data is only written on load, so the last word
  // is retained after a drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_valid <= 1'b0;
      r_a_data  <= '0;
    end else if (w_load_a) begin
      r_a_valid <= 1'b1;
      r_a_data  <= in_data;
    end else if (w_drain_a) begin
      r_a_valid <= 1'b0;
    end
  end

  // Port B holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b_valid <= 1'b0;
      r_b_data  <= '0;
    end else if (w_load_b) begin
      r_b_valid <= 1'b1;
      r_b_data  <= in_data;
    end else if (w_drain_b) begin
      r_b_valid <= 1'b0;
    end
  end

  assign out_a_data  = r_a_data;
  assign out_a_valid = r_a_valid;
  assign out_b_data  = r_b_data;
  assign out_b_valid = r_b_valid;

`ifdef DEMUX_COUNT_EN
  logic [15:0] r_cnt_a;
  logic [15:0] r_cnt_b;

  // Free-running transfer counters; natural 16-bit overflow gives the wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_a <= 16'h0000;
      r_cnt_b <= 16'h0000;
    end else begin
      if (w_drain_a) begin
        r_cnt_a <= r_cnt_a + 16'h0001;
      end
      if (w_drain_b) begin
        r_cnt_b <= r_cnt_b + 16'h0001;
      end
    end
  end

  assign cnt_a = r_cnt_a;
  assign cnt_b = r_cnt_b;
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux_1to2_32bit_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_1to2_32bit_reg
// Purpose  : Self-checking bench for demux_1to2_32bit_reg. Each port is
//            modelled as a queue of capacity one; words accepted by the
//            producer are pushed to the queue of their destination and a
//            monitor pops them when the consumer takes them.
// Revision : 1.0 - initial release
// Build option: DEMUX_COUNT_EN enables the transfer counter checks.
// ============================================================================
module tb_demux_1to2_32bit_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_sel = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_a_data;
  logic        out_a_valid;
  logic        out_a_ready = 1'b0;
  logic [31:0] out_b_data;
  logic        out_b_valid;
  logic        out_b_ready = 1'b0;
`ifdef DEMUX_COUNT_EN
  logic [15:0] cnt_a;
  logic [15:0] cnt_b;
`endif

  demux_1to2_32bit_reg #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_sel      (in_sel),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_a_data  (out_a_data),
    .out_a_valid (out_a_valid),
    .out_a_ready (out_a_ready),
    .out_b_data  (out_b_data),
    .out_b_valid (out_b_valid),
    .out_b_ready (out_b_ready)
`ifdef DEMUX_COUNT_EN
    ,
    .cnt_a       (cnt_a),
    .cnt_b       (cnt_b)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: each output port is a FIFO of capacity one.
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int          xfer_a = 0;
  int          xfer_b = 0;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: at every falling edge compare each port against its model queue
  // and retire a word whenever the port presents it to a ready consumer.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
`ifdef DEMUX_COUNT_EN
        check("cnt_a", {16'h0, cnt_a}, {16'h0, xfer_a[15:0]});
        check("cnt_b", {16'h0, cnt_b}, {16'h0, xfer_b[15:0]});
`endif
        check("a_valid", {31'h0, out_a_valid}, {31'h0, qa.size() != 0});
        if (qa.size() != 0) begin
          check("a_data", out_a_data, qa[0]);
          if (out_a_ready) begin
            void'(qa.pop_front());
            xfer_a++;
          end
        end
        check("b_valid", {31'h0, out_b_valid}, {31'h0, qb.size() != 0});
        if (qb.size() != 0) begin
          check("b_data", out_b_data, qb[0]);
          if (out_b_ready) begin
            void'(qb.pop_front());
            xfer_b++;
          end
        end
      end
    end
  end

  // One producer cycle: drive after the rising edge, then (after the monitor
  // has retired any drained word) predict in_ready from the model and push
  // the word if it is accepted.
  task automatic cyc(input logic v, input logic s, input logic [31:0] d,
                     input logic ra, input logic rb, output logic acc);
    logic exp_rdy;
    @(posedge clk);
    #1;
    in_valid    = v;
    in_sel      = s;
    in_data     = d;
    out_a_ready = ra;
    out_b_ready = rb;
    @(negedge clk);
    #1;
    exp_rdy = s ? (qb.size() == 0 || rb) : (qa.size() == 0 || ra);
    check("in_ready", {31'h0, in_ready}, {31'h0, exp_rdy});
    acc = v && exp_rdy;
    if (acc) begin
      if (s) qb.push_back(d);
      else   qa.push_back(d);
    end
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_a_valid", {31'h0, out_a_valid}, 32'h0);
    check("rst_b_valid", {31'h0, out_b_valid}, 32'h0);
    check("rst_a_data", out_a_data, 32'h0);
    check("rst_b_data", out_b_data, 32'h0);
    in_valid = 1'b0;
    qa.delete();
    qb.delete();
    xfer_a = 0;
    xfer_b = 0;
    in_sel = 1'b0;
    out_a_ready = 1'b0;
    #1;
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic        pv;
    logic        ps;
    logic [31:0] pd;

    // Power-up reset state.
    #2;
    check("por_a_valid", {31'h0, out_a_valid}, 32'h0);
    check("por_b_valid", {31'h0, out_b_valid}, 32'h0);
    check("por_a_data", out_a_data, 32'h0);
    check("por_b_data", out_b_data, 32'h0);
    check("por_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // First word to A.
    cyc(1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, acc);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, acc);

    // A stalled, then drain-and-refill.
    cyc(1'b1, 1'b0, 32'h11111111, 1'b0, 1'b0, acc);
    cyc(1'b1, 1'b0, 32'h22222222, 1'b0, 1'b0, acc);
    cyc(1'b1, 1'b0, 32'h22222222, 1'b0, 1'b0, acc);
    cyc(1'b1, 1'b0, 32'h22222222, 1'b1, 1'b0, acc);

    // A now holds 0x22222222 and is stalled; B still flows.
    cyc(1'b1, 1'b1, 32'h0000CAFE, 1'b0, 1'b0, acc);
    cyc(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, acc);
    cyc(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, acc);

    // Back-to-back stream to B.
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, i, 1'b0, 1'b1, acc);
    cyc(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, acc);

    // Fill both ports, then reset asynchronously between edges.
    cyc(1'b1, 1'b0, 32'hAAAA0001, 1'b0, 1'b0, acc);
    cyc(1'b1, 1'b1, 32'hBBBB0002, 1'b0, 1'b0, acc);
    async_reset();
    cyc(1'b1, 1'b0, 32'h0BADF00D, 1'b1, 1'b0, acc);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);

    // Randomized traffic; a refused word is held until accepted.
    pv = 1'b0;
    ps = 1'b0;
    pd = '0;
    for (int i = 0; i < 600; i++) begin
      if (!pv) begin
        pv = ($urandom_range(0, 3) != 0);
        ps = 1'($urandom_range(0, 1));
        pd = $urandom;
      end
      cyc(pv, ps, pd, ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 4), acc);
      if (acc || !pv) pv = 1'b0;
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);
    check("drained_a", qa.size(), 32'h0);
    check("drained_b", qb.size(), 32'h0);

`ifdef DEMUX_COUNT_EN
    // Counter wrap: 0x10000 transfers on A, 3 on B.
    async_reset();
    for (int i = 0; i < 32'h10000; i++) cyc(1'b1, 1'b0, i, 1'b1, 1'b0, acc);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, i, 1'b1, 1'b1, acc);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);
    @(posedge clk);
    #1;
    check("cnt_a_wrap", {16'h0, cnt_a}, 32'h0);
    check("cnt_b_three", {16'h0, cnt_b}, 32'h3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
